// File: rtl/fft_out_reorder_if.sv
// Sample stream bundle for the FFT output reorder block.
// Carries the bit-reversed input stream, the natural-order output stream
// and the sticky frame error flag.
interface fft_out_reorder_if #(
  parameter int BW = 16,
  parameter int AW = 7
);
  logic          valid;
  logic          start;
  logic [BW-1:0] inReal;
  logic [BW-1:0] inImag;
  logic          out_valid;
  logic          out_last;
  logic [AW-1:0] out_idx;
  logic [BW-1:0] outReal;
  logic [BW-1:0] outImag;
  logic          frame_err;

  // Producer side: drives samples in and observes the reordered stream
  modport master (
    output valid, start, inReal, inImag,
    input  out_valid, out_last, out_idx, outReal, outImag, frame_err
  );

  // Reorder block side
  modport slave (
    input  valid, start, inReal, inImag,
    output out_valid, out_last, out_idx, outReal, outImag, frame_err
  );
endinterface

// File: rtl/fft_out_reorder.sv
// FFT output reorder: converts a bit-reversed-order sample stream into
// natural order using two ping-pong banks of N_pt complex entries.
// The writer scatters each sample to bitrev(count) of its bank; the reader
// sweeps a full bank linearly with a registered (synchronous) read.
module fft_out_reorder #(
  parameter int N_pt = 128,
  parameter int BW   = 16,
  parameter int AW   = $clog2(N_pt)
) (
  input  logic              clk,
  input  logic              reset_n,
  fft_out_reorder_if.slave  bus
);

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

  // Mirror the index bits: bit i moves to bit AW-1-i
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = {AW{1'b0}};
    for (int i = 0; i < AW; i++) begin
      r[AW-1-i] = a[i];
    end
    return r;
  endfunction

  // Storage: bank select is the MSB of the address
  logic [2*BW-1:0] mem_q [0:2*N_pt-1];

  // Write-side state
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          open_q, open_d;
  logic          wr_bank_q, wr_bank_d;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [1:0]    set_full_s;
  logic          err_set_s;

  // Shared bank status
  logic [1:0]    full_q, full_d;
  logic          frame_err_q;

  // Read-side state
  rd_state_e     state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    clr_full_s;
  logic          issue_s;
  logic [2*BW-1:0] rd_word_s;

  // Output registers
  logic          out_valid_q;
  logic          out_last_q;
  logic [AW-1:0] out_idx_q;
  logic [BW-1:0] out_re_q;
  logic [BW-1:0] out_im_q;

  // Writer: start handling, frame abort, scatter address and frame close
  always_comb begin
    wr_en_s    = 1'b0;
    wr_addr_s  = IDX_ZERO;
    wr_cnt_d   = wr_cnt_q;
    open_d     = open_q;
    wr_bank_d  = wr_bank_q;
    set_full_s = 2'b00;
    err_set_s  = 1'b0;
    if (bus.valid && bus.start) begin
      // A start always restarts the frame in the current bank
      wr_en_s   = 1'b1;
      wr_addr_s = IDX_ZERO;
      wr_cnt_d  = IDX_ONE;
      open_d    = 1'b1;
      if (wr_cnt_q != IDX_ZERO) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = 1'b0;
      end
    end else if (bus.valid && open_q) begin
      wr_en_s   = 1'b1;
      wr_addr_s = bitrev(wr_cnt_q);
      if (wr_cnt_q == IDX_LAST) begin
        wr_cnt_d = IDX_ZERO;
        open_d   = 1'b0;
        if (full_q[wr_bank_q]) begin
          // Reader still owns this bank: drop the frame, keep the bank
          err_set_s = 1'b1;
        end else begin
          set_full_s[wr_bank_q] = 1'b1;
          wr_bank_d             = ~wr_bank_q;
        end
      end else begin
        wr_cnt_d = wr_cnt_q + IDX_ONE;
      end
    end else begin
      // Idle cycle, or stray samples before any start: nothing accepted
      wr_en_s = 1'b0;
    end
  end

  // Reader FSM: sweep a full bank, chaining straight into the next one
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_bank_d  = rd_bank_q;
    clr_full_s = 2'b00;
    issue_s    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = RD_READ;
          rd_addr_d = IDX_ZERO;
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_READ: begin
        issue_s = 1'b1;
        if (rd_addr_q == IDX_LAST) begin
          clr_full_s[rd_bank_q] = 1'b1;
          rd_bank_d             = ~rd_bank_q;
          rd_addr_d             = IDX_ZERO;
          if (full_q[~rd_bank_q]) begin
            state_d = RD_READ;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          rd_addr_d = rd_addr_q + IDX_ONE;
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // Full flags: reader clears and writer sets act on independent banks
  always_comb begin
    full_d = (full_q & ~clr_full_s) | set_full_s;
  end

  assign rd_word_s = mem_q[{rd_bank_q, rd_addr_q}];

  // Sample storage write port (contents intentionally not reset)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[{wr_bank_q, wr_addr_s}] <= {bus.inReal, bus.inImag};
    end
  end

  // Writer and bank-status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q    <= IDX_ZERO;
      open_q      <= 1'b0;
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      frame_err_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      open_q      <= open_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_q | err_set_s;
    end
  end

  // Reader FSM registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RD_IDLE;
      rd_addr_q <= IDX_ZERO;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Registered read port: data, index and flags one cycle after issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= IDX_ZERO;
      out_re_q    <= {BW{1'b0}};
      out_im_q    <= {BW{1'b0}};
    end else begin
      out_valid_q <= issue_s;
      out_last_q  <= issue_s && (rd_addr_q == IDX_LAST);
      if (issue_s) begin
        out_idx_q <= rd_addr_q;
        out_re_q  <= rd_word_s[2*BW-1:BW];
        out_im_q  <= rd_word_s[BW-1:0];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.outReal   = out_re_q;
  assign bus.outImag   = out_im_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: frames are driven in bit-reversed
// order, the natural-order expectation is queued when a frame completes,
// and every output beat is popped and compared.
module tb_fft_out_reorder;
  localparam int N_PT = 128;
  localparam int BW   = 16;
  localparam int AW   = 7;

  typedef struct {
    logic [AW-1:0] idx;
    logic [BW-1:0] re;
    logic [BW-1:0] im;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.BW(BW), .AW(AW)) bus ();

  fft_out_reorder #(.N_pt(N_PT), .BW(BW), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Monitor statistics, cleared between scenarios
  int   mon_cnt = 0, mon_first = 0, mon_last = 0, mon_gap = 0;
  bit   mon_seen = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) if (((v >> i) & 1) != 0) r |= 1 << (AW - 1 - i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: compare each output beat with the next queued expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.out_valid) begin
        exp_t e;
        mon_cnt++;
        if (!mon_seen) begin
          mon_first = cyc;
          mon_seen  = 1'b1;
        end
        mon_last = cyc;
        chk("unexpected_out", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_idx",  32'(bus.out_idx),  32'(e.idx));
          chk("outReal",  32'(bus.outReal),  32'(e.re));
          chk("outImag",  32'(bus.outImag),  32'(e.im));
          chk("out_last", 32'(bus.out_last), 32'(e.last));
        end
      end else begin
        chk("last_idle", 32'(bus.out_last), 32'd0);
        if (prev_valid && !prev_last) mon_gap++;
      end
      prev_valid = bus.out_valid;
      prev_last  = bus.out_last;
    end
  end

  task automatic drive(input logic v, input logic s, input logic [BW-1:0] re, input logic [BW-1:0] im);
    @(negedge clk);
    bus.valid  = v;
    bus.start  = s;
    bus.inReal = re;
    bus.inImag = im;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic clear_mon();
    @(negedge clk);
    #1;
    mon_cnt = 0; mon_first = 0; mon_last = 0; mon_gap = 0;
    mon_seen = 1'b0; prev_valid = 1'b0; prev_last = 1'b0;
  endtask

  // Drive one full frame; e_cyc is the edge that captures its last sample
  task automatic send_frame(input bit rnd, input bit gaps, output int e_cyc);
    logic [BW-1:0] re_a [N_PT];
    logic [BW-1:0] im_a [N_PT];
    exp_t e;
    for (int k = 0; k < N_PT; k++) begin
      re_a[k] = rnd ? BW'($urandom) : BW'(k);
      im_a[k] = rnd ? BW'($urandom) : BW'(-k);
    end
    for (int k = 0; k < N_PT; k++) begin
      if (gaps && ($urandom_range(1, 0) == 1)) drive(1'b0, 1'b0, 16'hdead, 16'hbeef);
      drive(1'b1, (k == 0), re_a[k], im_a[k]);
    end
    e_cyc = cyc + 1;
    for (int n = 0; n < N_PT; n++) begin
      e.idx  = AW'(n);
      e.re   = re_a[bitrev(n)];
      e.im   = im_a[bitrev(n)];
      e.last = (n == N_PT - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int e1, e2, e3;
    bit found;
    bus.valid = 1'b0; bus.start = 1'b0; bus.inReal = '0; bus.inImag = '0;

    // Reset state
    #2;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last",  32'(bus.out_last),  32'd0);
    chk("rst_idx",   32'(bus.out_idx),   32'd0);
    chk("rst_re",    32'(bus.outReal),   32'd0);
    chk("rst_im",    32'(bus.outImag),   32'd0);
    chk("rst_err",   32'(bus.frame_err), 32'd0);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    // Samples without a start are ignored
    clear_mon();
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, BW'(k), BW'(k));
    idle(20);
    chk("nostart_cnt", 32'(mon_cnt), 32'd0);

    // Single ramp frame with latency check
    clear_mon();
    send_frame(1'b0, 1'b0, e1);
    idle(1);
    wait_drain();
    chk("single_cnt",   32'(mon_cnt),   32'd128);
    chk("single_first", 32'(mon_first), 32'(e1 + 2));
    chk("single_lastc", 32'(mon_last),  32'(e1 + N_PT + 1));
    chk("single_gap",   32'(mon_gap),   32'd0);
    chk("single_err",   32'(bus.frame_err), 32'd0);

    // Three frames back to back
    clear_mon();
    send_frame(1'b1, 1'b0, e1);
    send_frame(1'b1, 1'b0, e2);
    send_frame(1'b0, 1'b0, e3);
    idle(1);
    wait_drain();
    chk("b2b_cnt",   32'(mon_cnt),   32'd384);
    chk("b2b_first", 32'(mon_first), 32'(e1 + 2));
    chk("b2b_lastc", 32'(mon_last),  32'(e3 + N_PT + 1));
    chk("b2b_span",  32'(mon_last - mon_first + 1), 32'd384);
    chk("b2b_err",   32'(bus.frame_err), 32'd0);

    // Gapped input
    clear_mon();
    send_frame(1'b0, 1'b1, e1);
    idle(1);
    wait_drain();
    chk("gap_cnt",   32'(mon_cnt),   32'd128);
    chk("gap_first", 32'(mon_first), 32'(e1 + 2));
    chk("gap_lastc", 32'(mon_last),  32'(e1 + N_PT + 1));
    chk("gap_gaps",  32'(mon_gap),   32'd0);

    // Early start after 40 samples aborts the partial frame
    clear_mon();
    for (int k = 0; k < 40; k++) drive(1'b1, (k == 0), 16'h7777, 16'h1111);
    send_frame(1'b1, 1'b0, e1);
    idle(1);
    wait_drain();
    chk("abort_err",   32'(bus.frame_err), 32'd1);
    chk("abort_cnt",   32'(mon_cnt),   32'd128);
    chk("abort_first", 32'(mon_first), 32'(e1 + 2));

    // Reset pulse in the middle of an output frame
    clear_mon();
    send_frame(1'b1, 1'b0, e1);
    idle(1);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_idx == AW'(60)) found = 1'b1;
    end
    chk("rst60_found", 32'(found), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst60_valid", 32'(bus.out_valid), 32'd0);
    chk("rst60_last",  32'(bus.out_last),  32'd0);
    chk("rst60_idx",   32'(bus.out_idx),   32'd0);
    chk("rst60_re",    32'(bus.outReal),   32'd0);
    chk("rst60_im",    32'(bus.outImag),   32'd0);
    chk("rst60_err",   32'(bus.frame_err), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    clear_mon();
    idle(150);
    chk("rst60_residual", 32'(mon_cnt), 32'd0);
    clear_mon();
    send_frame(1'b1, 1'b0, e1);
    idle(1);
    wait_drain();
    chk("post_cnt",   32'(mon_cnt),   32'd128);
    chk("post_first", 32'(mon_first), 32'(e1 + 2));
    chk("post_err",   32'(bus.frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
